// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// operation codes, sequencer state encoding and the operand latch layout.
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mfhi  = 4'd5,
        MDU_mflo  = 4'd6,
        MDU_mthi  = 4'd7,
        MDU_mtlo  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    // True for the ops that occupy the unit for a multi-cycle run.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational result generator: latched op/operands -> new HI/LO.
// hold is raised for a zero divisor (and for non mul/div ops) so the
// sequencer leaves HI/LO untouched.
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        hold
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Signed division works on magnitudes so truncation is toward zero and
    // the remainder takes the dividend's sign; 0x80000000/-1 falls out
    // naturally as quotient 0x80000000, remainder 0.  A zero divisor is
    // replaced by 1 purely to keep the operators defined; the result is
    // discarded through hold.
    always_comb begin
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};
        mag_a   = a[31] ? (~a + 32'd1) : a;
        mag_b   = b[31] ? (~b + 32'd1) : b;
        if (b == 32'd0) begin
            mag_b = 32'd1;
        end
        div_b_u = (b == 32'd0) ? 32'd1 : b;
        q_mag   = mag_a / mag_b;
        r_mag   = mag_a % mag_b;
        q_u     = a / div_b_u;
        r_u     = a % div_b_u;
    end

    // Select the result for the latched op.
    always_comb begin
        hi_next = 32'd0;
        lo_next = 32'd0;
        hold    = 1'b1;
        case (op)
            MDU_mult: begin
                {hi_next, lo_next} = prod_s;
                hold = 1'b0;
            end
            MDU_multu: begin
                {hi_next, lo_next} = prod_u;
                hold = 1'b0;
            end
            MDU_div: begin
                lo_next = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                hi_next = a[31] ? (~r_mag + 32'd1) : r_mag;
                hold    = (b == 32'd0);
            end
            MDU_divu: begin
                lo_next = q_u;
                hi_next = r_u;
                hold    = (b == 32'd0);
            end
            default: begin
                hold = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer with architectural HI/LO.
//
// state    | meaning
// ---------+----------------------------------------------------------
// MDU_IDLE | unit free; accepts mul/div, mthi/mtlo act immediately
// MDU_RUN  | op in flight; count runs down, HI/LO written at count==0
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] MDUout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    mdu_state_e       state;
    mdu_state_e       state_nxt;
    logic [CNT_W-1:0] count;
    mdu_req_t         req;
    logic             accept;
    logic             last;
    logic             op_is_mult;
    logic [31:0]      hi_next;
    logic [31:0]      lo_next;
    logic             hold;

    // Starts are only taken while idle; anything arriving during RUN is dropped.
    assign accept     = (state == MDU_IDLE) && start && is_muldiv(MDUOp);
    assign last       = (state == MDU_RUN) && (count == '0);
    assign op_is_mult = (MDUOp == MDU_mult) || (MDUOp == MDU_multu);

    e_mdu_arith u_arith (
        .op      (req.op),
        .a       (req.a),
        .b       (req.b),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .hold    (hold)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (accept) state_nxt = MDU_RUN;
            MDU_RUN:  if (count == '0) state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    // FSM outputs: busy tracks RUN, stall_req also covers the start cycle.
    always_comb begin
        busy      = (state == MDU_RUN);
        stall_req = busy || (start && is_muldiv(MDUOp));
    end

    // Latency down-counter, loaded with N-1 on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (accept) begin
            count <= op_is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        end else if ((state == MDU_RUN) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Operand latch, written only on accept so A/B may move during RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req <= '0;
        end else if (accept) begin
            req <= '{op: MDUOp, a: A, b: B};
        end
    end

    // HI/LO: result write on the final RUN edge, or direct mthi/mtlo while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (last) begin
            if (!hold) begin
                HI <= hi_next;
                LO <= lo_next;
            end
        end else if ((state == MDU_IDLE) && start) begin
            if (MDUOp == MDU_mthi) HI <= A;
            if (MDUOp == MDU_mtlo) LO <= A;
        end
    end

    // Combinational move-from read path.
    always_comb begin
        MDUout = 32'd0;
        if (MDUOp == MDU_mfhi) MDUout = HI;
        if (MDUOp == MDU_mflo) MDUout = LO;
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl; expected {HI,LO} results are queued at
// issue and popped when busy falls.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  MDUOp;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] MDUout;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MDUOp     (MDUOp),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .MDUout    (MDUout),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
        MDUOp = op;
        A     = a;
        B     = b;
        start = st;
    endtask

    // Count busy-high cycles until busy drops (bounded), then score HI/LO.
    task automatic wait_busy(input string tag, input int n);
        int          cycles;
        logic [63:0] exp;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            else break;
        end
        chk({tag, "_busy_cycles"}, 32'(cycles), 32'(n));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_HI"}, HI, exp[63:32]);
            chk({tag, "_LO"}, LO, exp[31:0]);
        end else begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic run_muldiv(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int n, input logic [63:0] exp);
        @(posedge clk); #1;
        drive(op, a, b, 1'b1);
        exp_q.push_back(exp);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(stall_req), 32'd1);
        chk({tag, "_busy_pre"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        drive(MDU_none, $urandom, $urandom, 1'b0);
        wait_busy(tag, n);
    endtask

    initial begin
        int hits;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(MDU_none, 32'd0, 32'd0, 1'b0);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_muldiv("mult_neg", MDU_mult, 32'hFFFF_FFFE, 32'd3, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_muldiv("multu_max", MDU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, {32'hFFFF_FFFE, 32'h0000_0001});
        run_muldiv("div_neg", MDU_div, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_muldiv("divu", MDU_divu, 32'hFFFF_FFF9, 32'd2, 10, {32'h0000_0001, 32'h7FFF_FFFC});
        run_muldiv("div_negdivisor", MDU_div, 32'd7, 32'hFFFF_FFFE, 10, {32'h0000_0001, 32'hFFFF_FFFD});
        run_muldiv("div_ovf", MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'h0000_0000, 32'h8000_0000});

        // mthi / mtlo then move-from reads
        @(posedge clk); #1 drive(MDU_mthi, 32'h1234_5678, 32'd0, 1'b1);
        @(negedge clk); chk("mthi_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1 drive(MDU_mfhi, 32'd0, 32'd0, 1'b1);
        @(negedge clk); chk("mfhi", MDUout, 32'h1234_5678);
        chk("mfhi_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 drive(MDU_mtlo, 32'h0000_00AA, 32'd0, 1'b1);
        @(posedge clk); #1 drive(MDU_mflo, 32'd0, 32'd0, 1'b1);
        @(negedge clk); chk("mflo", MDUout, 32'h0000_00AA);
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);

        run_muldiv("divu_zero", MDU_divu, 32'd55, 32'd0, 10, {32'h1234_5678, 32'h0000_00AA});

        // mult presented during a div run is dropped
        @(posedge clk); #1 drive(MDU_div, 32'd100, 32'd7, 1'b1);
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 drive(MDU_mult, 32'd5, 32'd6, 1'b1);
        @(negedge clk); chk("midrun_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1 drive(MDU_none, $urandom, $urandom, 1'b0);
        wait_busy("midrun_div", 7);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) hits++;
        end
        chk("midrun_no_rebusy", 32'(hits), 32'd0);

        // start on the final RUN cycle is dropped
        @(posedge clk); #1 drive(MDU_div, 32'd9, 32'd3, 1'b1);
        exp_q.push_back({32'd0, 32'd3});
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 drive(MDU_mult, 32'd4, 32'd4, 1'b1);
        @(negedge clk); chk("lastcyc_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        wait_busy("lastcyc_div", 0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) hits++;
        end
        chk("lastcyc_no_rebusy", 32'(hits), 32'd0);

        // none / undefined codes have no effect
        @(posedge clk); #1 drive(4'hF, 32'hDEAD_BEEF, 32'd1, 1'b1);
        @(negedge clk); chk("undef_stall", 32'(stall_req), 32'd0);
        chk("undef_out", MDUout, 32'd0);
        @(posedge clk); #1 drive(MDU_none, 32'hDEAD_BEEF, 32'd1, 1'b1);
        @(negedge clk); chk("none_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_HI", HI, 32'd0);
        chk("undef_LO", LO, 32'd3);

        // asynchronous reset mid-div (count==4) aborts without a write
        @(posedge clk); #1 drive(MDU_mthi, 32'h1111_1111, 32'd0, 1'b1);
        @(posedge clk); #1 drive(MDU_mtlo, 32'h2222_2222, 32'd0, 1'b1);
        @(posedge clk); #1 drive(MDU_div, 32'd1000, 32'd3, 1'b1);
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_HI", HI, 32'd0);
        chk("arst_LO", LO, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        drive(MDU_mflo, 32'd0, 32'd0, 1'b1);
        @(negedge clk); chk("arst_mflo", MDUout, 32'd0);
        @(posedge clk); #1 drive(MDU_none, 32'd0, 32'd0, 1'b0);
        repeat (12) @(negedge clk);
        chk("arst_later_busy", 32'(busy), 32'd0);
        chk("arst_later_HI", HI, 32'd0);
        chk("arst_later_LO", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
